// File: rtl/dct_to_px_adapter.sv
// rtl/dct_to_px_adapter.sv - 8x8 block rows in, raster pixels out through a ping-pong stripe buffer
module dct_to_px_adapter #(
    parameter int PX_WIDTH       = 8,
    parameter int FRAME_RES_X    = 1280,
    parameter int PX_TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [8*PX_WIDTH-1:0]     par_tdata_i,
    input  logic                      par_tvalid_i,
    output logic                      par_tready_o,
    input  logic                      par_tuser_i,
    output logic [PX_TDATA_WIDTH-1:0] px_tdata_o,
    output logic                      px_tvalid_o,
    input  logic                      px_tready_i,
    output logic                      px_tlast_o,
    output logic                      px_tuser_o
);
    localparam int BLKS = FRAME_RES_X / 8;
    localparam int BLK_W = (BLKS > 1) ? $clog2(BLKS) : 1;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLKS - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t bank_state [2];
    bank_state_t bank_state_nxt [2];
    logic [1:0] sof, sof_nxt;

    logic wr_bank, wr_bank_nxt;
    logic [2:0] wr_row, wr_row_nxt, wr_addr_row;
    logic [BLK_W-1:0] wr_blk, wr_blk_nxt, wr_addr_blk;
    logic wr_fire, wr_restart, wr_done, ready_nxt;

    logic rd_bank, rd_bank_nxt;
    logic [2:0] rd_line, rd_line_nxt, rd_px, rd_px_nxt;
    logic [BLK_W-1:0] rd_blk, rd_blk_nxt;
    logic rd_avail, rd_issue, rd_eol, rd_end;

    logic [8*PX_WIDTH-1:0] mem [2][8][BLKS];
    logic [8*PX_WIDTH-1:0] s1_word;
    logic [2:0] s1_lane;
    logic s1_valid, s1_last, s1_user, s1_free, s1_bank;
    logic o_free, o_bank;
    logic out_ready, s1_ready, px_free;
    logic [PX_WIDTH-1:0] lane_px;

    assign wr_fire     = par_tvalid_i & par_tready_o;
    // A frame start arriving mid-stripe restarts the current bank from its first beat.
    assign wr_restart  = par_tuser_i & ((wr_row != 3'd0) | (wr_blk != '0));
    assign wr_addr_row = wr_restart ? 3'd0 : wr_row;
    assign wr_addr_blk = wr_restart ? '0 : wr_blk;
    assign wr_done     = wr_fire & ~wr_restart & (wr_row == 3'd7) & (wr_blk == LAST_BLK);

    assign out_ready = ~px_tvalid_o | px_tready_i;
    assign s1_ready  = ~s1_valid | out_ready;
    assign rd_avail  = (bank_state[rd_bank] == FULL) | (bank_state[rd_bank] == DRAINING);
    assign rd_issue  = rd_avail & s1_ready;
    assign rd_eol    = (rd_px == 3'd7) & (rd_blk == LAST_BLK);
    assign rd_end    = rd_issue & rd_eol & (rd_line == 3'd7);
    // The bank is released only when its final pixel leaves the output register.
    assign px_free   = px_tvalid_o & px_tready_i & o_free;
    assign lane_px   = s1_word[s1_lane*PX_WIDTH +: PX_WIDTH];

    always_comb begin
        wr_row_nxt     = wr_row;
        wr_blk_nxt     = wr_blk;
        wr_bank_nxt    = wr_bank;
        rd_px_nxt      = rd_px;
        rd_blk_nxt     = rd_blk;
        rd_line_nxt    = rd_line;
        rd_bank_nxt    = rd_bank;
        bank_state_nxt = bank_state;
        sof_nxt        = sof;

        if (wr_fire) begin
            if (wr_restart) begin
                wr_row_nxt = 3'd1;
                wr_blk_nxt = '0;
            end else if (wr_row == 3'd7) begin
                wr_row_nxt = 3'd0;
                wr_blk_nxt = (wr_blk == LAST_BLK) ? '0 : wr_blk + 1'b1;
            end else begin
                wr_row_nxt = wr_row + 3'd1;
            end
            if (wr_done) wr_bank_nxt = ~wr_bank;
        end

        if (rd_issue) begin
            rd_px_nxt = rd_px + 3'd1;
            if (rd_px == 3'd7) rd_blk_nxt = (rd_blk == LAST_BLK) ? '0 : rd_blk + 1'b1;
            if (rd_eol) rd_line_nxt = rd_line + 3'd1;
            if (rd_end) rd_bank_nxt = ~rd_bank;
        end

        for (int i = 0; i < 2; i++) begin
            if (wr_fire && wr_bank == 1'(i)) begin
                if (bank_state[i] == EMPTY) bank_state_nxt[i] = FILLING;
                if (wr_addr_row == 3'd0 && wr_addr_blk == '0) sof_nxt[i] = par_tuser_i;
                if (wr_done) bank_state_nxt[i] = FULL;
            end
            if (rd_issue && rd_bank == 1'(i) && bank_state[i] == FULL) bank_state_nxt[i] = DRAINING;
            if (px_free && o_bank == 1'(i)) begin
                bank_state_nxt[i] = EMPTY;
                sof_nxt[i]        = 1'b0;
            end
        end

        ready_nxt = (bank_state_nxt[wr_bank_nxt] == EMPTY) | (bank_state_nxt[wr_bank_nxt] == FILLING);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_state   <= '{EMPTY, EMPTY};
            sof          <= '0;
            wr_bank      <= 1'b0;
            wr_row       <= '0;
            wr_blk       <= '0;
            rd_bank      <= 1'b0;
            rd_line      <= '0;
            rd_px        <= '0;
            rd_blk       <= '0;
            par_tready_o <= 1'b0;
            s1_valid     <= 1'b0;
            s1_lane      <= '0;
            s1_last      <= 1'b0;
            s1_user      <= 1'b0;
            s1_free      <= 1'b0;
            s1_bank      <= 1'b0;
            px_tvalid_o  <= 1'b0;
            px_tdata_o   <= '0;
            px_tlast_o   <= 1'b0;
            px_tuser_o   <= 1'b0;
            o_free       <= 1'b0;
            o_bank       <= 1'b0;
        end else begin
            bank_state   <= bank_state_nxt;
            sof          <= sof_nxt;
            wr_bank      <= wr_bank_nxt;
            wr_row       <= wr_row_nxt;
            wr_blk       <= wr_blk_nxt;
            rd_bank      <= rd_bank_nxt;
            rd_line      <= rd_line_nxt;
            rd_px        <= rd_px_nxt;
            rd_blk       <= rd_blk_nxt;
            par_tready_o <= ready_nxt;
            if (s1_ready) begin
                s1_valid <= rd_issue;
                s1_lane  <= rd_px;
                s1_last  <= rd_eol;
                s1_user  <= sof[rd_bank] & (rd_line == 3'd0) & (rd_blk == '0) & (rd_px == 3'd0);
                s1_free  <= rd_end;
                s1_bank  <= rd_bank;
            end
            if (out_ready) begin
                px_tvalid_o <= s1_valid;
                px_tdata_o  <= PX_TDATA_WIDTH'(lane_px);
                px_tlast_o  <= s1_valid & s1_last;
                px_tuser_o  <= s1_valid & s1_user;
                o_free      <= s1_valid & s1_free;
                o_bank      <= s1_bank;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem[wr_bank][wr_addr_row][wr_addr_blk] <= par_tdata_i;
        if (rd_issue) s1_word <= mem[rd_bank][rd_line][rd_blk];
    end
endmodule

// File: tb/tb_dct_to_px_adapter.sv
// tb/tb_dct_to_px_adapter.sv - self-checking bench for dct_to_px_adapter
module tb_dct_to_px_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [63:0] par_tdata = '0;
    logic        par_tvalid = 1'b0;
    logic        par_tready;
    logic        par_tuser = 1'b0;
    logic [7:0]  px_tdata;
    logic        px_tvalid;
    logic        px_tready = 1'b1;
    logic        px_tlast;
    logic        px_tuser;

    dct_to_px_adapter #(.PX_WIDTH(8), .FRAME_RES_X(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .par_tdata_i(par_tdata), .par_tvalid_i(par_tvalid), .par_tready_o(par_tready),
        .par_tuser_i(par_tuser),
        .px_tdata_o(px_tdata), .px_tvalid_o(px_tvalid), .px_tready_i(px_tready),
        .px_tlast_o(px_tlast), .px_tuser_o(px_tuser)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       last;
        logic       user;
    } vec_t;

    vec_t vecs [6];
    int checks = 0;
    int failures = 0;
    int accepted = 0;
    logic [7:0] q_data [$];
    logic       q_last [$];
    logic       q_user [$];
    bit mon_en = 0, stall_p = 0;
    logic [7:0] stall_d;
    logic stall_l, stall_u;
    bit gap_en = 0, gap_seen = 0;
    int gaps = 0, gap_target = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_p) begin
                chk("stall_valid", px_tvalid, 1);
                chk("stall_data", px_tdata, stall_d);
                chk("stall_last", px_tlast, stall_l);
                chk("stall_user", px_tuser, stall_u);
            end
            stall_p = px_tvalid && !px_tready;
            stall_d = px_tdata;
            stall_l = px_tlast;
            stall_u = px_tuser;
            if (px_tvalid && px_tready) begin
                q_data.push_back(px_tdata);
                q_last.push_back(px_tlast);
                q_user.push_back(px_tuser);
            end
            if (gap_en) begin
                if (px_tvalid) gap_seen = 1;
                else if (gap_seen && q_data.size() < gap_target) gaps++;
            end
        end else begin
            stall_p = 0;
        end
    end

    function automatic logic [7:0] val(input int s, input int r, input int x);
        return 8'((s * 37 + r * 16 + x) & 255);
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic u);
        bit done = 0;
        int t = 0;
        par_tdata = d;
        par_tuser = u;
        par_tvalid = 1'b1;
        while (!done && t < 1000) begin
            @(negedge clk);
            done = par_tready;
            @(posedge clk);
            #1;
            t++;
        end
        par_tvalid = 1'b0;
        par_tuser = 1'b0;
        if (done) accepted++;
        else chk("in_beat_timeout", 0, 1);
    endtask

    task automatic send_stripes(input int n, input int s0, input bit first_user);
        logic [63:0] d;
        for (int s = 0; s < n; s++)
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++) begin
                    for (int k = 0; k < 8; k++) d[k*8 +: 8] = val(s0 + s, r, b * 8 + k);
                    send_beat(d, first_user && s == 0 && b == 0 && r == 0);
                end
    endtask

    task automatic wait_pixels(input string name, input int n, input int budget);
        int t = 0;
        while (q_data.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (q_data.size() < n) chk(name, q_data.size(), n);
    endtask

    task automatic check_stream(input string name, input int n, input int s0, input bit first_user);
        int s, r, x;
        chk($sformatf("%s_count", name), q_data.size(), n);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            s = i / 128;
            r = (i / 16) % 8;
            x = i % 16;
            chk($sformatf("%s_data[%0d]", name, i), q_data[i], val(s0 + s, r, x));
            chk($sformatf("%s_last[%0d]", name, i), q_last[i], x == 15);
            chk($sformatf("%s_user[%0d]", name, i), q_user[i], first_user && i == 0);
        end
    endtask

    task automatic check_vectors(input string name);
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].idx < q_data.size()) begin
                chk($sformatf("%s_vec_data[%0d]", name, vecs[i].idx), q_data[vecs[i].idx], vecs[i].data);
                chk($sformatf("%s_vec_last[%0d]", name, vecs[i].idx), q_last[vecs[i].idx], vecs[i].last);
                chk($sformatf("%s_vec_user[%0d]", name, vecs[i].idx), q_user[vecs[i].idx], vecs[i].user);
            end else begin
                chk($sformatf("%s_vec_present[%0d]", name, vecs[i].idx), 0, 1);
            end
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        rst_n = 1'b0;
        par_tvalid = 1'b0;
        par_tuser = 1'b0;
        par_tdata = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_px_tvalid", px_tvalid, 0);
        chk("rst_px_tdata", px_tdata, 0);
        chk("rst_px_tlast", px_tlast, 0);
        chk("rst_px_tuser", px_tuser, 0);
        chk("rst_par_tready", par_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready_low", par_tready, 0);
        @(posedge clk);
        #1;
        chk("rst_ready_rises", par_tready, 1);
        q_data.delete();
        q_last.delete();
        q_user.delete();
        accepted = 0;
        mon_en = 1;
    endtask

    initial begin
        int t;
        vecs[0] = '{idx: 0,   data: 8'd0,   last: 1'b0, user: 1'b1};
        vecs[1] = '{idx: 7,   data: 8'd7,   last: 1'b0, user: 1'b0};
        vecs[2] = '{idx: 15,  data: 8'd15,  last: 1'b1, user: 1'b0};
        vecs[3] = '{idx: 16,  data: 8'd16,  last: 1'b0, user: 1'b0};
        vecs[4] = '{idx: 79,  data: 8'd79,  last: 1'b1, user: 1'b0};
        vecs[5] = '{idx: 127, data: 8'd127, last: 1'b1, user: 1'b0};

        // single stripe, latency and raster order
        px_tready = 1'b1;
        do_reset();
        send_stripes(1, 0, 1);
        @(negedge clk);
        chk("s1_latency_c0", px_tvalid, 0);
        @(negedge clk);
        chk("s1_latency_c1", px_tvalid, 0);
        @(negedge clk);
        chk("s1_latency_c2", px_tvalid, 1);
        wait_pixels("s1_timeout", 128, 400);
        check_stream("s1", 128, 0, 1);
        check_vectors("s1");

        // output stalled: input must stop after both banks are filled
        px_tready = 1'b0;
        do_reset();
        fork
            send_stripes(3, 0, 1);
            begin
                t = 0;
                while (accepted < 32 && t < 300) begin
                    @(negedge clk);
                    t++;
                end
                repeat (20) @(negedge clk);
                chk("s2_accepted", accepted, 32);
                chk("s2_ready_low", par_tready, 0);
                chk("s2_no_output", q_data.size(), 0);
                px_tready = 1'b1;
            end
        join
        wait_pixels("s2_timeout", 384, 2000);
        check_stream("s2", 384, 0, 1);

        // random output back-pressure
        do_reset();
        fork
            send_stripes(1, 0, 1);
            begin
                t = 0;
                while (q_data.size() < 128 && t < 2000) begin
                    @(posedge clk);
                    #1;
                    px_tready = 1'($urandom_range(0, 1));
                    t++;
                end
                px_tready = 1'b1;
            end
        join
        wait_pixels("s3_timeout", 128, 400);
        check_stream("s3", 128, 0, 1);
        check_vectors("s3");

        // frame start on beat 5 discards the partial stripe
        px_tready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) send_beat({8{8'(8'hF0 + i)}}, 1'b0);
        send_stripes(1, 3, 1);
        wait_pixels("s4_timeout", 128, 400);
        repeat (40) @(negedge clk);
        check_stream("s4", 128, 3, 1);

        // asynchronous reset mid-drain
        do_reset();
        send_stripes(1, 1, 1);
        wait_pixels("s5_drain_timeout", 40, 400);
        @(negedge clk);
        chk("s5_pre_valid", px_tvalid, 1);
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_async_tvalid", px_tvalid, 0);
        chk("s5_async_tdata", px_tdata, 0);
        chk("s5_async_tlast", px_tlast, 0);
        chk("s5_async_tuser", px_tuser, 0);
        chk("s5_async_ready", par_tready, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        q_data.delete();
        q_last.delete();
        q_user.delete();
        mon_en = 1;
        repeat (30) @(negedge clk);
        chk("s5_no_output_after_reset", q_data.size(), 0);
        chk("s5_idle_valid", px_tvalid, 0);
        send_stripes(1, 2, 1);
        wait_pixels("s5_timeout", 128, 400);
        check_stream("s5", 128, 2, 1);

        // continuous streaming, no output bubbles across four stripes
        do_reset();
        gaps = 0;
        gap_seen = 0;
        gap_target = 512;
        gap_en = 1;
        send_stripes(4, 4, 1);
        wait_pixels("s6_timeout", 512, 2000);
        gap_en = 0;
        chk("s6_gaps", gaps, 0);
        check_stream("s6", 512, 4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
